y_vector_writer: RTL and testbench

//  Consumer end of the intermediator's y stream (push_to_y / v_to_y). Buffers finished
//  row sums, converts the 66-bit internal float to IEEE-754 double, and issues sequential
//  8-byte writes to y[] through the MC request port. Counts write acks and raises done

---
 rtl/y_vector_writer.sv | 164 ++++++++++++++++
 tb/tb_y_vector_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y_vector_writer.sv
// Drains finished y row sums: buffers them, converts the 66-bit internal float to an
// IEEE double, writes them sequentially to y[] and raises done once every write is acked.
module y_vector_writer #(
  parameter int unsigned FIFO_DEPTH        = 32,
  parameter int unsigned ALMOST_FULL_COUNT = 16,
  parameter int unsigned ADDR_WIDTH        = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] y_base_addr,
  input  logic [31:0]           y_row_count,
  input  logic                  push_y,
  input  logic [65:0]           v_y,
  output logic                  y_almost_full,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [63:0]           mem_req_data,
  input  logic                  mem_req_stall,
  input  logic                  mem_rsp_valid,
  output logic                  done,
  output logic                  overflow_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [63:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_fifo_cnt;
  logic [OCC_W-1:0]      r_occ;
  logic [ADDR_WIDTH-1:0] r_base_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [31:0]           r_row_count;
  logic [31:0]           r_accepted;
  logic [31:0]           r_issued;
  logic [31:0]           r_acked;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [63:0]           r_req_data;
  logic                  r_done;
  logic                  r_almost_full;
  logic                  r_overflow;

  logic                  w_start;
  logic                  w_taken;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_ack;
  logic [OCC_W-1:0]      w_occ_nxt;
  logic [63:0]           w_conv;

  // Occupancy counts the held request too, so total storage equals FIFO_DEPTH.
  assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_taken   = r_req_valid && !mem_req_stall;
  assign w_pop     = (r_fifo_cnt != '0) && (!r_req_valid || w_taken);
  assign w_full    = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_accept  = push_y && (r_state == S_RUN) && (r_accepted < r_row_count)
                     && (!w_full || w_taken);
  assign w_ack     = mem_rsp_valid && ((r_state == S_RUN) || (r_state == S_DRAIN))
                     && (r_acked < r_row_count);
  assign w_occ_nxt = r_occ + OCC_W'(w_accept) - OCC_W'(w_taken);

  // Internal float to IEEE double, selected by the exception field.
  always_comb begin
    w_conv = 64'h7FF8_0000_0000_0000;
    unique case (v_y[65:64])
      2'b00:   w_conv = {v_y[63], 63'b0};
      2'b01:   w_conv = v_y[63:0];
      2'b10:   w_conv = {v_y[63], 11'h7FF, 52'b0};
      default: w_conv = 64'h7FF8_0000_0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = (y_row_count == 32'd0) ? S_DONE : S_RUN;
      S_RUN:          if (r_issued == r_row_count) w_state_nxt = S_DRAIN;
      S_DRAIN:        if (r_acked == r_row_count) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_conv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_fifo_cnt    <= '0;
      r_occ         <= '0;
      r_base_addr   <= '0;
      r_next_addr   <= '0;
      r_row_count   <= '0;
      r_accepted    <= '0;
      r_issued      <= '0;
      r_acked       <= '0;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_req_data    <= '0;
      r_done        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_done        <= (w_state_nxt == S_DONE);
      r_almost_full <= (w_occ_nxt >= OCC_W'(ALMOST_FULL_COUNT));
      r_occ         <= w_occ_nxt;
      r_fifo_cnt    <= r_fifo_cnt + OCC_W'(w_accept) - OCC_W'(w_pop);
      if (push_y && !w_accept) r_overflow <= 1'b1;
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_accepted <= r_accepted + 32'd1;
      end
      if (w_taken) r_issued <= r_issued + 32'd1;
      if (w_ack)   r_acked  <= r_acked + 32'd1;
      // Output register: refill from the head whenever it is empty or being taken.
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_req_valid <= 1'b1;
        r_req_addr  <= r_next_addr;
        r_req_data  <= r_mem[r_rd_ptr];
        r_next_addr <= r_next_addr + ADDR_WIDTH'(8);
      end else if (w_taken) begin
        r_req_valid <= 1'b0;
      end
      if (w_start) begin
        r_base_addr <= y_base_addr;
        r_next_addr <= y_base_addr;
        r_row_count <= y_row_count;
        r_accepted  <= '0;
        r_issued    <= '0;
        r_acked     <= '0;
      end
    end
  end

  assign y_almost_full = r_almost_full;
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_data  = r_req_data;
  assign done          = r_done;
  assign overflow_err  = r_overflow;

endmodule

// File: tb/tb_y_vector_writer.sv
// Directed and randomized bench for y_vector_writer with a queue-based reference model.
module tb_y_vector_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] y_base_addr;
  logic [31:0] y_row_count;
  logic        push_y;
  logic [65:0] v_y;
  logic        y_almost_full;
  logic        mem_req_valid;
  logic [47:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic        mem_req_stall;
  logic        mem_rsp_valid;
  logic        done;
  logic        overflow_err;

  always #5 clk = ~clk;

  y_vector_writer dut (
    .clk(clk), .rst(rst), .start(start), .y_base_addr(y_base_addr),
    .y_row_count(y_row_count), .push_y(push_y), .v_y(v_y),
    .y_almost_full(y_almost_full), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_stall(mem_req_stall), .mem_rsp_valid(mem_rsp_valid),
    .done(done), .overflow_err(overflow_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: expected write stream plus job bookkeeping.
  logic [47:0] q_addr[$];
  logic [63:0] q_data[$];
  logic [47:0] m_base = '0;
  int unsigned m_count = 0, m_accepted = 0, m_taken = 0, m_acked = 0, m_acks_sent = 0;
  bit          m_active = 0, m_ovf = 0;

  function automatic logic [63:0] ref_conv(input logic [65:0] v);
    case (v[65:64])
      2'b00:   return {v[63], 63'b0};
      2'b01:   return v[63:0];
      2'b10:   return {v[63], 11'h7FF, 52'b0};
      default: return 64'h7FF8_0000_0000_0000;
    endcase
  endfunction

  function automatic logic [65:0] rand66();
    return {2'($urandom), $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q_addr.delete();
    q_data.delete();
    m_count = 0; m_accepted = 0; m_taken = 0; m_acked = 0; m_acks_sent = 0;
    m_active = 0; m_ovf = 0;
  endtask

  // One clock: update the model from the inputs/outputs seen this cycle, then check after the edge.
  task automatic tick();
    bit          taken, held, acc;
    int unsigned occ;
    logic [47:0] h_addr;
    logic [63:0] h_data;
    taken  = (mem_req_valid === 1'b1) && (mem_req_stall === 1'b0);
    held   = (mem_req_valid === 1'b1) && (mem_req_stall === 1'b1);
    h_addr = mem_req_addr;
    h_data = mem_req_data;
    occ    = m_accepted - m_taken;
    if (!rst) begin
      if (taken) begin
        if (q_addr.size() == 0) chk("write_expected", 64'(mem_req_valid), 64'd0);
        else begin
          chk("wr_addr", 64'(mem_req_addr), 64'(q_addr.pop_front()));
          chk("wr_data", mem_req_data, q_data.pop_front());
          m_taken++;
        end
      end
      acc = push_y && m_active && (m_accepted < m_count) && ((occ < 32) || taken);
      if (acc) begin
        q_addr.push_back(m_base + 48'(m_accepted) * 48'd8);
        q_data.push_back(ref_conv(v_y));
        m_accepted++;
      end else if (push_y) m_ovf = 1;
      if (mem_rsp_valid && m_active && (m_acked < m_count)) m_acked++;
      if (start && !(m_active && (m_acked < m_count))) begin
        m_base = y_base_addr; m_count = y_row_count;
        m_accepted = 0; m_taken = 0; m_acked = 0; m_acks_sent = 0;
        m_active = (y_row_count != 0);
      end
    end
    @(posedge clk);
    #1;
    if (rst) model_clear();
    else if (held) begin
      chk("stall_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_addr", 64'(mem_req_addr), 64'(h_addr));
      chk("stall_data", mem_req_data, h_data);
    end
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("almost_full", 64'(y_almost_full), 64'((m_accepted - m_taken) >= 16));
    if (q_addr.size() == 0) chk("idle_valid", 64'(mem_req_valid), 64'd0);
    if (m_active && (m_acked < m_count)) chk("done_low", 64'(done), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic do_start(input logic [47:0] base, input logic [31:0] cnt);
    y_base_addr = base; y_row_count = cnt; start = 1; tick(); start = 0;
  endtask

  // Feed remaining rows with random pushes/stalls/acks until done (bounded).
  task automatic drain_job(input int stall_pct, input int push_pct);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 4000) begin
      push_y        = (m_accepted < m_count) && ($urandom_range(0, 99) < push_pct);
      v_y           = rand66();
      mem_req_stall = ($urandom_range(0, 99) < stall_pct);
      mem_rsp_valid = (m_taken > m_acks_sent) && ($urandom_range(0, 1) == 1);
      if (mem_rsp_valid) m_acks_sent++;
      tick();
      n++;
      seen = (done === 1'b1);
    end
    push_y = 0; mem_req_stall = 0; mem_rsp_valid = 0;
    chk("done_reached", 64'(done), 64'd1);
    chk("writes_total", 64'(m_taken), 64'(m_count));
    chk("queue_empty", 64'(q_addr.size()), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1; start = 0; y_base_addr = '0; y_row_count = '0; push_y = 0; v_y = '0;
    mem_req_stall = 0; mem_rsp_valid = 0;
    do_reset();
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valid", 64'(mem_req_valid), 64'd0);
    chk("reset_ovf", 64'(overflow_err), 64'd0);

    // Push while idle is dropped; zero-row job completes immediately.
    push_y = 1; v_y = rand66(); tick(); push_y = 0;
    chk("idle_push_ovf", 64'(overflow_err), 64'd1);
    do_start(48'h2000, 32'd0);
    chk("zero_done", 64'(done), 64'd1);
    tick(); tick();
    chk("zero_no_req", 64'(mem_req_valid), 64'd0);
    chk("zero_done_held", 64'(done), 64'd1);
    do_reset();

    // Three back-to-back rows; first request two cycles after the first push.
    do_start(48'h1000, 32'd3);
    push_y = 1; v_y = {2'b01, 64'h3FF0_0000_0000_0000}; tick();
    chk("lat_t1_valid", 64'(mem_req_valid), 64'd0);
    v_y = {2'b01, 64'h4000_0000_0000_0000}; tick();
    chk("lat_t2_valid", 64'(mem_req_valid), 64'd1);
    chk("lat_t2_addr", 64'(mem_req_addr), 64'h1000);
    v_y = {2'b01, 64'hC008_0000_0000_0000}; tick();
    push_y = 0;
    drain_job(0, 100);

    // Exception-field conversions.
    do_start(48'h5000, 32'd3);
    push_y = 1; v_y = {2'b00, 1'b1, 63'h1234_5678_9ABC_DEF0}; tick(); push_y = 0; tick();
    chk("exc00_data", mem_req_data, 64'h8000_0000_0000_0000);
    push_y = 1; v_y = {2'b10, 1'b0, 63'h0ABC_DEF0_1234_5678}; tick(); push_y = 0; tick();
    chk("exc10_data", mem_req_data, 64'h7FF0_0000_0000_0000);
    push_y = 1; v_y = {2'b11, 64'hFFFF_0000_1111_2222}; tick(); push_y = 0; tick();
    chk("exc11_data", mem_req_data, 64'h7FF8_0000_0000_0000);
    drain_job(0, 100);

    // Ten rows with a five-cycle stall in the middle.
    do_start(48'hABC0, 32'd10);
    for (int i = 0; i < 14; i++) begin
      push_y = (i < 10); v_y = rand66();
      mem_req_stall = (i >= 4 && i < 9);
      tick();
    end
    push_y = 0; mem_req_stall = 0;
    drain_job(0, 100);

    // Randomized jobs, one crossing the top of the address space.
    for (int j = 0; j < 5; j++) begin
      logic [47:0] b;
      b = (j == 0) ? 48'hFFFF_FFFF_FFF0 : ({16'($urandom), $urandom} & ~48'h7);
      do_start(b, 32'($urandom_range(1, 30)));
      drain_job(int'($urandom_range(0, 50)), 60);
    end

    // Fill under a held stall: 33rd push overflows, 32 writes drain afterwards.
    do_reset();
    do_start(48'h1_0000, 32'd40);
    mem_req_stall = 1; push_y = 1;
    for (int i = 0; i < 33; i++) begin
      v_y = rand66();
      tick();
      if (i == 14) chk("af_at_15", 64'(y_almost_full), 64'd0);
      if (i == 15) chk("af_at_16", 64'(y_almost_full), 64'd1);
      if (i == 31) chk("no_ovf_at_32", 64'(overflow_err), 64'd0);
    end
    push_y = 0;
    chk("full_ovf", 64'(overflow_err), 64'd1);
    mem_req_stall = 0;
    n = 0;
    while (m_taken < 32 && n < 100) begin tick(); n++; end
    chk("full_writes", 64'(m_taken), 64'd32);
    drain_job(20, 70);

    // Reset with four writes outstanding, then a clean two-row job.
    do_reset();
    do_start(48'h8000, 32'd8);
    push_y = 1;
    for (int i = 0; i < 4; i++) begin v_y = rand66(); tick(); end
    push_y = 0;
    n = 0;
    while (m_taken < 4 && n < 50) begin tick(); n++; end
    chk("pre_rst_taken", 64'(m_taken), 64'd4);
    rst = 1; tick(); rst = 0;
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    mem_rsp_valid = 1;
    for (int i = 0; i < 4; i++) tick();
    mem_rsp_valid = 0;
    chk("stale_done", 64'(done), 64'd0);
    do_start(48'h9000, 32'd2);
    drain_job(10, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
